// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter: per-requester valid/ready with packed operands,
// plus a single tagged response stream.
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*4-1:0]  req_op;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU among NREQ requesters with a registered, tagged response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic         clk,
    input logic         rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [IDW-1:0]  ptr_q;
`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0]  ptr_d;
`else
    assign ptr_q = '0;
`endif

    logic            can_accept;
    logic            found;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] grant;
    int unsigned     scan_idx;
    logic [3:0]      sel_op;
    logic [31:0]     sel_a, sel_b, sel_b_eff, alu_out, result;

    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = {31'd0, $signed(a) < $signed(b)};
            4'd8:  r = {31'd0, a == b};
            4'd9:  r = {31'd0, a != b};
            4'd10: r = {31'd0, $signed(a) >= $signed(b)};
            4'd11: r = {31'd0, a < b};
            4'd12: r = {31'd0, a >= b};
            4'd13: r = a * b;
            4'd14: r = a / b;
            default: r = a % b;
        endcase
        return r;
    endfunction

    assign can_accept = (state_q == StIdle) || bus.rsp_ready;

    // Scan from the pointer with wrap; the first valid requester wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_idx = int'(ptr_q) + off;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!found && bus.req_valid[scan_idx]) begin
                found     = 1'b1;
                grant_idx = IDW'(scan_idx);
            end
        end
        if (!can_accept || rst) found = 1'b0;
        grant = found ? (NREQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        sel_op    = bus.req_op[4*grant_idx +: 4];
        sel_a     = bus.req_a[32*grant_idx +: 32];
        sel_b     = bus.req_b[32*grant_idx +: 32];
        sel_b_eff = (sel_op == 4'd5 || sel_op == 4'd6) ? {27'd0, sel_b[4:0]} : sel_b;
        alu_out   = alu_calc(sel_op, sel_a, sel_b_eff);
        // RV32 divide-by-zero results override whatever the divider produced.
        if (sel_op == 4'd14 && sel_b == '0)      result = 32'hFFFF_FFFF;
        else if (sel_op == 4'd15 && sel_b == '0) result = sel_a;
        else                                     result = alu_out;
    end

    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
`ifdef ALU_ARB_RR_EN
        ptr_d        = ptr_q;
`endif
        if (found) begin
            state_d      = StHold;
            rsp_id_d     = grant_idx;
            rsp_result_d = result;
`ifdef ALU_ARB_RR_EN
            ptr_d        = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
`endif
        end else if (state_q == StHold && bus.rsp_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
`ifdef ALU_ARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
`ifdef ALU_ARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = (state_q == StHold);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
endmodule
